// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and
// small helpers used by both the shifter core and its output stage.
package barrel_shift_pkg;

  localparam int MAX_W = 128;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_ROL = 3'b011,
    OP_ROR = 3'b100
  } op_e;

  function automatic logic is_reserved(input logic [2:0] op);
    return op > OP_ROR;
  endfunction

  function automatic logic is_right(input logic [2:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction

  function automatic logic is_rotate(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] bit_reverse(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] src;
    logic [MAX_W-1:0] r;
    src = v;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        r = {r[MAX_W-2:0], src[0]};
        src = src >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_layer.sv
// One combinational log-shifter layer: left shift by SHIFT when enabled,
// either wrapping (rotate) or filling the vacated low bits with fill_i.
module bs_layer #(
  parameter int DATA_W = 32,
  parameter int SHIFT  = 1
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              en_i,
  input  logic              rot_i,
  input  logic              fill_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      if (rot_i) begin
        data_o = {data_i[DATA_W-SHIFT-1:0], data_i[DATA_W-1:DATA_W-SHIFT]};
      end else begin
        data_o = {data_i[DATA_W-SHIFT-1:0], {SHIFT{fill_i}}};
      end
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter with valid/ready backpressure. Right-hand ops are
// bit-reversed on entry and exit so every layer only ever shifts left.
module barrel_shifter_pipe
  import barrel_shift_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_EVERY = 2,
  localparam int SHAMT_W  = $clog2(DATA_W),
  localparam int LAT      = (SHAMT_W + REG_EVERY - 1) / REG_EVERY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_err
);

  logic [DATA_W-1:0]  data_q  [LAT];
  logic [DATA_W-1:0]  data_d  [LAT];
  logic [SHAMT_W-1:0] shamt_q [LAT];
  logic [SHAMT_W-1:0] shamt_d [LAT];
  logic [2:0]         op_q    [LAT];
  logic [2:0]         op_d    [LAT];
  logic               fill_q  [LAT];
  logic               fill_d  [LAT];
  logic               err_q   [LAT];
  logic               err_d   [LAT];
  logic [LAT-1:0]     valid_q;
  logic [LAT-1:0]     valid_d;

  logic [DATA_W-1:0]  src_data  [LAT];
  logic [SHAMT_W-1:0] src_shamt [LAT];
  logic [2:0]         src_op    [LAT];
  logic               src_fill  [LAT];
  logic               src_err   [LAT];
  logic [LAT-1:0]     src_valid;
  logic [DATA_W-1:0]  stage_out [LAT];
  logic [LAT-1:0]     adv;

  // Stage 0 is fed from the ports (pre-reversed for right ops); later stages
  // are fed from the previous register group.
  always_comb begin
    src_data[0]  = is_right(in_op) ? DATA_W'(bit_reverse(MAX_W'(in_data), DATA_W)) : in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = in_op;
    src_fill[0]  = (in_op == OP_SRA) && in_data[DATA_W-1];
    src_err[0]   = is_reserved(in_op);
    src_valid[0] = in_valid;
    for (int s = 1; s < LAT; s++) begin
      src_data[s]  = data_q[s-1];
      src_shamt[s] = shamt_q[s-1];
      src_op[s]    = op_q[s-1];
      src_fill[s]  = fill_q[s-1];
      src_err[s]   = err_q[s-1];
      src_valid[s] = valid_q[s-1];
    end
  end

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_layer
    localparam int ST = i / REG_EVERY;
    logic [DATA_W-1:0] l_in;
    logic [DATA_W-1:0] l_out;

    if (i % REG_EVERY == 0) begin : g_head
      assign l_in = src_data[ST];
    end else begin : g_chain
      assign l_in = g_layer[i-1].l_out;
    end

    bs_layer #(
      .DATA_W(DATA_W),
      .SHIFT (1 << i)
    ) u_layer (
      .data_i(l_in),
      .en_i  (src_shamt[ST][i] && !src_err[ST]),
      .rot_i (is_rotate(src_op[ST])),
      .fill_i(src_fill[ST]),
      .data_o(l_out)
    );

    if ((i % REG_EVERY == REG_EVERY - 1) || (i == SHAMT_W - 1)) begin : g_tail
      assign stage_out[ST] = l_out;
    end
  end

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    adv = '0;
    adv[LAT-1] = !valid_q[LAT-1] || out_ready;
    for (int s = LAT - 2; s >= 0; s--) begin
      adv[s] = !valid_q[s] || adv[s+1];
    end
  end

  always_comb begin
    for (int s = 0; s < LAT; s++) begin
      valid_d[s] = valid_q[s];
      data_d[s]  = data_q[s];
      shamt_d[s] = shamt_q[s];
      op_d[s]    = op_q[s];
      fill_d[s]  = fill_q[s];
      err_d[s]   = err_q[s];
      if (adv[s]) begin
        valid_d[s] = src_valid[s];
        if (src_valid[s]) begin
          data_d[s]  = stage_out[s];
          shamt_d[s] = src_shamt[s];
          op_d[s]    = src_op[s];
          fill_d[s]  = src_fill[s];
          err_d[s]   = src_err[s];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < LAT; s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= '0;
        fill_q[s]  <= 1'b0;
        err_q[s]   <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < LAT; s++) begin
        data_q[s]  <= data_d[s];
        shamt_q[s] <= shamt_d[s];
        op_q[s]    <= op_d[s];
        fill_q[s]  <= fill_d[s];
        err_q[s]   <= err_d[s];
      end
    end
  end

  always_comb begin
    in_ready  = adv[0];
    out_valid = valid_q[LAT-1];
    out_err   = err_q[LAT-1];
    out_data  = is_right(op_q[LAT-1]) ?
                DATA_W'(bit_reverse(MAX_W'(data_q[LAT-1]), DATA_W)) : data_q[LAT-1];
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench for barrel_shifter_pipe (DATA_W=32, REG_EVERY=2, LAT=3)
// using directed vectors plus randomized traffic against a behavioural model.
module tb_barrel_shifter_pipe;

  localparam int DATA_W = 32;
  localparam int SW     = 5;
  localparam int LAT    = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SW-1:0]     in_shamt;
  logic [2:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  int n_cmp;
  int n_bad;

  barrel_shifter_pipe #(
    .DATA_W   (DATA_W),
    .REG_EVERY(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {err, result} from plain shift arithmetic.
  function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic [2:0] op);
    logic [31:0] r;
    logic        e;
    logic [5:0]  inv;
    e   = 1'b0;
    inv = 6'd32 - {1'b0, s};
    case (op)
      3'd0: r = d << s;
      3'd1: r = d >> s;
      3'd2: r = 32'($signed(d) >>> s);
      3'd3: r = (d << s) | (d >> inv);
      3'd4: r = (d >> s) | (d << inv);
      default: begin
        r = d;
        e = 1'b1;
      end
    endcase
    return {e, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one transaction into an empty pipeline and measures its latency.
  task automatic run_single(input logic [31:0] d, input logic [4:0] s, input logic [2:0] op,
                            output logic [31:0] got, output logic gerr, output int lat);
    out_ready = 1'b1;
    in_data   = d;
    in_shamt  = s;
    in_op     = op;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    got  = out_data;
    gerr = out_err;
    tick();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = '0;
    out_ready = 1'b1;
    #2;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_outputs: got v=%b d=%h e=%b expected v=0 d=0 e=0",
               out_valid, out_data, out_err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t        v [13];
    logic [31:0] got;
    logic        gerr;
    int          lat;
    v[0] = '{32'hA5A5A5A5, 5'd2, 3'd0, 32'h96969694};
    v[1] = '{32'hA5A5A5A5, 5'd2, 3'd1, 32'h29696969};
    v[2] = '{32'hA5A5A5A5, 5'd4, 3'd2, 32'hFA5A5A5A};
    v[3] = '{32'hA5A5A5A5, 5'd4, 3'd4, 32'h5A5A5A5A};
    v[4] = '{32'h12345678, 5'd8, 3'd3, 32'h34567812};
    v[5] = '{32'h00000001, 5'd31, 3'd0, 32'h80000000};
    v[6] = '{32'h80000000, 5'd31, 3'd2, 32'hFFFFFFFF};
    v[7] = '{32'h80000000, 5'd31, 3'd1, 32'h00000001};
    for (int i = 0; i < 5; i++) begin
      logic [31:0] r;
      r = $urandom | 32'h80000001;
      v[8+i] = '{r, 5'd0, 3'(i), r};
    end
    for (int i = 0; i < 13; i++) begin
      run_single(v[i].d, v[i].s, v[i].op, got, gerr, lat);
      n_cmp++;
      if (lat !== LAT) begin
        n_bad++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT);
      end
      n_cmp++;
      if (got !== v[i].exp) begin
        n_bad++;
        $display("[TB] FAIL directed_data[%0d]: got %h expected %h", i, got, v[i].exp);
      end
      n_cmp++;
      if (gerr !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL directed_err[%0d]: got %b expected 0", i, gerr);
      end
    end
  endtask

  task automatic test_reserved();
    logic [31:0] got;
    logic        gerr;
    int          lat;
    run_single(32'hDEADBEEF, 5'd5, 3'b111, got, gerr, lat);
    n_cmp++;
    if (got !== 32'hDEADBEEF || gerr !== 1'b1 || lat !== LAT) begin
      n_bad++;
      $display("[TB] FAIL reserved_op: got d=%h e=%b lat=%0d expected d=deadbeef e=1 lat=%0d",
               got, gerr, lat, LAT);
    end
    run_single(32'h00000001, 5'd4, 3'd0, got, gerr, lat);
    n_cmp++;
    if (got !== 32'h00000010 || gerr !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL after_reserved: got d=%h e=%b expected d=00000010 e=0", got, gerr);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] expq[$];
    logic [31:0] td [5];
    logic [4:0]  ts [5];
    logic [2:0]  to [5];
    logic [31:0] held;
    logic [32:0] e;
    int          k;
    int          got_n;
    for (int i = 0; i < 5; i++) begin
      td[i] = $urandom;
      ts[i] = 5'($urandom_range(1, 31));
      to[i] = 3'($urandom_range(0, 4));
    end
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = td[k];
      in_shamt = ts[k];
      in_op    = to[k];
      #4;
      n_cmp++;
      if (in_ready !== (c < 3)) begin
        n_bad++;
        $display("[TB] FAIL stall_in_ready[%0d]: got %b expected %b", c, in_ready, c < 3);
      end
      if (in_ready) begin
        expq.push_back(model(td[k], ts[k], to[k]));
        k++;
      end
      tick();
    end
    held = out_data;
    for (int c = 0; c < 3; c++) begin
      in_data = $urandom;
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL stall_hold[%0d]: got v=%b d=%h rdy=%b expected v=1 d=%h rdy=0",
                 c, out_valid, out_data, in_ready, held);
      end
    end
    out_ready = 1'b1;
    got_n = 0;
    for (int c = 0; c < 30 && got_n < 5; c++) begin
      in_valid = (k < 5);
      if (k < 5) begin
        in_data  = td[k];
        in_shamt = ts[k];
        in_op    = to[k];
      end
      #4;
      if (out_valid) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL drain_extra: got unexpected result %h expected none", out_data);
        end else begin
          e = expq.pop_front();
          if (out_data !== e[31:0] || out_err !== e[32]) begin
            n_bad++;
            $display("[TB] FAIL drain_data[%0d]: got %h/%b expected %h/%b",
                     got_n, out_data, out_err, e[31:0], e[32]);
          end
        end
        got_n++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(td[k], ts[k], to[k]));
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got_n !== 5 || k !== 5) begin
      n_bad++;
      $display("[TB] FAIL drain_count: got %0d out/%0d in expected 5/5", got_n, k);
    end
    repeat (4) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL drain_dup: got out_valid=%b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_throughput();
    logic [32:0] expq[$];
    logic [32:0] e;
    logic [31:0] td [16];
    logic [4:0]  ts [16];
    logic [2:0]  to [16];
    int          k;
    int          got_n;
    int          first;
    int          last;
    for (int i = 0; i < 16; i++) begin
      td[i] = $urandom;
      ts[i] = 5'($urandom);
      to[i] = 3'($urandom);
    end
    out_ready = 1'b1;
    k = 0;
    got_n = 0;
    first = -1;
    last = -1;
    for (int c = 0; c < 40 && got_n < 16; c++) begin
      in_valid = (k < 16);
      if (k < 16) begin
        in_data  = td[k];
        in_shamt = ts[k];
        in_op    = to[k];
      end
      #4;
      if (in_valid) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_bad++;
          $display("[TB] FAIL tput_in_ready[%0d]: got %b expected 1", c, in_ready);
        end
      end
      if (out_valid) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL tput_extra: got %h expected none", out_data);
        end else begin
          e = expq.pop_front();
          if (out_data !== e[31:0] || out_err !== e[32]) begin
            n_bad++;
            $display("[TB] FAIL tput_data[%0d]: got %h/%b expected %h/%b",
                     got_n, out_data, out_err, e[31:0], e[32]);
          end
        end
        if (first < 0) first = c;
        last = c;
        got_n++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(td[k], ts[k], to[k]));
        k++;
      end
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got_n !== 16 || first !== LAT || last - first !== 15) begin
      n_bad++;
      $display("[TB] FAIL tput_rate: got n=%0d first=%0d span=%0d expected n=16 first=%0d span=15",
               got_n, first, last - first, LAT);
    end
  endtask

  task automatic test_reset_inflight();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_shamt = 5'($urandom);
      in_op    = 3'($urandom_range(0, 4));
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL inflight_pre: got out_valid=%b expected 1", out_valid);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL async_reset: got v=%b d=%h e=%b expected v=0 d=0 e=0",
               out_valid, out_data, out_err);
    end
    tick();
    tick();
    #4;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL release_in_ready: got %b expected 1", in_ready);
    end
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL stale_after_reset[%0d]: got out_valid=%b expected 0", c, out_valid);
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_reserved();
    test_back_to_back();
    test_throughput();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
